vga_fb_fetch: RTL and testbench
===============================

// Module: vga_fb_fetch
// PURPOSE
// - Framebuffer prefetch stage between dmem and the vga pixel generator.
// - Replaces toggle-based ARM/VGA address muxing with cycle-stealing arbitration:
//   - ARM data accesses always win.
//   - Idle dmem cycles fetch framebuffer words into a FIFO.
// - Output: pixels unpacked from those words, streamed to vga over valid/ready.
// PARAMETERS
// - FB_BASE    32'h0000_1000  byte address of first framebuffer word (word aligned)
// - FB_WORDS   19200          words per frame (640x480 px / 16 px per word)
// - PIX_W      2              bits per pixel; 32 % PIX_W == 0
// - FIFO_DEPTH 16             word FIFO entries, power of two, >= 2
// PORTS
// - clk          in   1      system clock (same as arm/dmem)
// - reset        in   1      synchronous, active-high
// - arm_req      in   1      ARM performs a dmem access this cycle (load or store)
// - arm_addr     in   32     ARM data address
// - mem_addr     out  32     address driven to dmem
// - mem_rdata    in   32     dmem read data (combinational read, valid same cycle)
// - frame_start  in   1      1-cycle pulse from vga at start of vertical blanking
// - pix_ready    in   1      vga consumes pix_data this cycle
// - pix_valid    out  1      pix_data holds a valid pixel
// - pix_data     out  PIX_W  current pixel
// - underflow    out  1      sticky: vga requested a pixel while none was valid
// BEHAVIOUR
// - Address mux (combinational): mem_addr = arm_req ? arm_addr : fetch_addr.
// - FSM, states IDLE / RUN / DONE; reset -> IDLE.
//   - IDLE -(frame_start)-> RUN
//   - RUN -(FB_WORDS-th word pushed)-> DONE
//   - any state -(frame_start)-> RUN
// - Fetch issue: a cycle issues when state==RUN && !arm_req && fifo_count<FIFO_DEPTH.
//   - mem_rdata is pushed into the FIFO at the end of that same cycle.
//   - fetch_addr += 4 and words_fetched += 1.
//   - No fetch issues in IDLE or DONE, or while arm_req=1; the ARM never stalls.
// - Unpacker: holds one word and a pixel index (0..32/PIX_W-1).
//   - Pixel 0 = bits [PIX_W-1:0] (LSB first).
//   - pix_valid=1 while a word is loaded.
//   - Pop = pix_valid && pix_ready; index advances.
//   - On pop of the last pixel: load the next FIFO word in the same cycle if FIFO is non-empty (no bubble).
//     Otherwise pix_valid=0 next cycle.
//   - Empty unpacker loads from a non-empty FIFO in 1 cycle.
//   - Simultaneous FIFO push and pop are both honoured; count unchanged.
//   - Push when full cannot happen by construction; assertion required.
// - Latency: word fetched in cycle N -> first pixel visible on pix_data at N+1 if unpacker was empty.
// - underflow:
//   - Set when state!=IDLE && pix_ready && !pix_valid.
//   - Cleared only by reset or frame_start.
//   - When set and cleared in the same cycle, the clear wins.
// - frame_start priority: overrides a same-cycle push, pop and FSM transition.
//   - FIFO flushed, unpacker emptied (pix_valid=0 next cycle).
//   - fetch_addr=FB_BASE, words_fetched=0, state=RUN.
// - Wrap-around: fetch_addr never exceeds FB_BASE+4*(FB_WORDS-1); DONE halts fetch until the next frame.
// - Reset values: state=IDLE, fetch_addr=FB_BASE, FIFO empty, pix_valid=0, pix_data=0, underflow=0.
//   - mem_addr follows arm_addr.
//   - Reset mid-frame discards all buffered words.
// STRUCTURE
// - Package vga_fb_pkg:
//   - fb_state_t enum {IDLE,RUN,DONE}.
//   - PIX_PER_WORD = 32/PIX_W.
//   - Default FB_BASE/FB_WORDS localparams shared with the vga module and linker map.
// - One sub-module: sync_fifo #(WIDTH=32, DEPTH=FIFO_DEPTH).
//   - push/pop/flush, full/empty/count.
//   - Synchronous flush; reset is synchronous and active-high.
// - FSM, counters, address mux and unpacker stay in vga_fb_fetch.
// TESTING
// - Reset then frame_start, arm_req=0, pix_ready=0, mem_rdata = address ->
//   - 16 fetches at addresses 0x1000..0x103C.
//   - Fetch then stops (FIFO full).
//   - pix_valid=1, pix_data=2'b00.
// - Word 32'hE4E4_E4E4 loaded, pix_ready=1 continuous -> pix_data sequence 0,1,2,3 repeating.
//   - No bubble across the word boundary.
// - arm_req=1 on alternating cycles, arm_addr=0x80 -> mem_addr=0x80 on those cycles.
//   - fetch_addr advances only on the other cycles.
// - FB_WORDS=20, continuous pix_ready ->
//   - Exactly 20 fetches, last at 0x104C.
//   - State DONE, no further fetch.
//   - After draining, underflow=1 and stays 1.
// - frame_start mid-frame with FIFO half full and underflow=1 -> next cycle:
//   - FIFO empty, pix_valid=0, underflow=0.
//   - Next fetch at 0x1000.
// - reset asserted for one cycle mid-RUN -> all outputs at reset values.
//   - No fetch until the next frame_start.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared framebuffer constants and types for the vga fetch path.
// Defaults also match the vga module and the linker map.
package vga_fb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fb_state_t;

  localparam logic [31:0] FB_BASE_DEF = 32'h0000_1000;
  localparam int FB_WORDS_DEF = 19200;
  localparam int PIX_W_DEF = 2;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int PIX_PER_WORD = 32 / PIX_W_DEF;

  function automatic int pix_per_word(input int pw);
    return 32 / pw;
  endfunction

endpackage

// File: rtl/vga_fb_fetch_fifo.sv
// Synchronous word FIFO with flush; read data is the current head.
// Reset and flush are synchronous and active-high.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/vga_fb_fetch.sv
// Framebuffer prefetch: steals idle dmem cycles to fill a word FIFO
// and streams unpacked pixels to the vga generator.
module vga_fb_fetch
  import vga_fb_pkg::*;
#(
  parameter logic [31:0] FB_BASE    = FB_BASE_DEF,
  parameter int          FB_WORDS   = FB_WORDS_DEF,
  parameter int          PIX_W      = PIX_W_DEF,
  parameter int          FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm_req,
  input  logic [31:0]      arm_addr,
  output logic [31:0]      mem_addr,
  input  logic [31:0]      mem_rdata,
  input  logic             frame_start,
  input  logic             pix_ready,
  output logic             pix_valid,
  output logic [PIX_W-1:0] pix_data,
  output logic             underflow
);

  localparam int PPW = pix_per_word(PIX_W);
  localparam int IW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int WW  = $clog2(FB_WORDS + 1);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  fb_state_t     state_q;
  fb_state_t     state_d;
  logic [31:0]   fetch_addr;
  logic [WW-1:0] words;
  logic [IW-1:0] idx;
  logic [31:0]   fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fetch;
  logic          push;
  logic          last_word;
  logic          last_pix;
  logic          pix_pop;
  logic          word_pop;
  logic [31:0]   shifted;

  assign mem_addr  = arm_req ? arm_addr : fetch_addr;
  assign fetch     = (state_q == RUN) && !arm_req
                     && (fifo_count < CW'(FIFO_DEPTH));
  assign push      = fetch && !frame_start;
  assign last_word = words == WW'(FB_WORDS - 1);

  // The unpacker is a view of the FIFO head; the word leaves
  // the FIFO only when its last pixel is consumed.
  assign pix_valid = !fifo_empty;
  assign pix_pop   = pix_valid && pix_ready;
  assign last_pix  = idx == IW'(PPW - 1);
  assign word_pop  = pix_pop && last_pix && !frame_start;
  assign shifted   = fifo_rdata >> (PIX_W * int'(idx));
  assign pix_data  = pix_valid ? shifted[PIX_W-1:0] : '0;

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .wdata(mem_rdata),
    .pop  (word_pop),
    .flush(frame_start),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      frame_start:                      state_d = RUN;
      !frame_start && fetch && last_word: state_d = DONE;
      default: ;
    endcase
  end

  // Address wraps to the base after the last word of the frame.
  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      fetch_addr <= FB_BASE;
      words      <= '0;
      idx        <= '0;
    end else begin
      if (fetch) begin
        words      <= words + 1'b1;
        fetch_addr <= last_word ? FB_BASE : fetch_addr + 32'd4;
      end
      if (pix_pop) idx <= last_pix ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || frame_start)
      underflow <= 1'b0;
    else if (state_q != IDLE && pix_ready && !pix_valid)
      underflow <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && fifo_full));
  end

endmodule

// File: tb/tb_vga_fb_fetch.sv
// Scoreboard bench for vga_fb_fetch: directed frames, pixels
// checked by a negedge monitor against an expected queue.
module tb_vga_fb_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm_req;
  logic [31:0] arm_addr;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        frame_start;
  logic        pix_ready;
  logic        pix_valid;
  logic [1:0]  pix_data;
  logic        underflow;
  logic        rdata_mode;
  logic        stream_on;

  int tests = 0;
  int fails = 0;
  int pix_seen = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  assign mem_rdata = rdata_mode ? 32'hE4E4_E4E4 : mem_addr;

  vga_fb_fetch #(
    .FB_WORDS(20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .arm_req    (arm_req),
    .arm_addr   (arm_addr),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .frame_start(frame_start),
    .pix_ready  (pix_ready),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .underflow  (underflow)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 16; i++) exp_q.push_back(w[2*i +: 2]);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      tick();
      n++;
    end
    check({name, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!reset && pix_valid && pix_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pixel: got %0d expected none", pix_data);
      end else begin
        if (pix_data !== exp_q[0]) begin
          fails++;
          $display("FAIL pixel[%0d]: got %0d expected %0d",
                   pix_seen, pix_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      pix_seen++;
    end else if (stream_on && pix_ready && exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL bubble: got pix_valid %0d expected 1", pix_valid);
    end
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    arm_req = 1'b1;
    arm_addr = 32'h80;
    frame_start = 1'b0;
    pix_ready = 1'b0;
    rdata_mode = 1'b0;
    stream_on = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_mem_addr_arm", mem_addr, 32'h80);
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_pix_data", 32'(pix_data), 0);
    check("rst_underflow", 32'(underflow), 0);

    tick();
    reset = 1'b0;
    arm_req = 1'b0;
    pix_ready = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    check("idle_underflow", 32'(underflow), 0);
    check("idle_pix_valid", 32'(pix_valid), 0);
    check("idle_mem_addr", mem_addr, 32'h1000);

    // Fill: 16 fetches then stall on a full FIFO
    tick();
    pix_ready = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (24) tick();
    @(negedge clk);
    check("fill_mem_addr", mem_addr, 32'h1040);
    check("fill_pix_valid", 32'(pix_valid), 1);
    check("fill_pix_data", 32'(pix_data), 0);
    check("fill_underflow", 32'(underflow), 0);

    // Drain the whole 20-word frame
    tick();
    for (int k = 0; k < 20; k++) push_word(32'h1000 + 32'(4 * k));
    stream_on = 1'b1;
    pix_ready = 1'b1;
    drain("frame20");
    stream_on = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("done_underflow", 32'(underflow), 1);
    check("done_pix_valid", 32'(pix_valid), 0);
    repeat (20) tick();
    @(negedge clk);
    check("done_hold_underflow", 32'(underflow), 1);
    check("done_hold_pix_valid", 32'(pix_valid), 0);

    // Pattern word with alternating ARM traffic
    tick();
    pix_ready = 1'b0;
    rdata_mode = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      arm_req = (k % 2) == 0;
      @(negedge clk);
      if (k == 0) begin
        check("fs_underflow_clr", 32'(underflow), 0);
        check("fs_pix_valid", 32'(pix_valid), 0);
      end
      if (arm_req) check("arm_mem_addr", mem_addr, 32'h80);
      else check("steal_mem_addr", mem_addr, 32'h1000 + 32'(4 * (k / 2)));
      tick();
    end
    arm_req = 1'b0;
    for (int k = 0; k < 20; k++) push_word(32'hE4E4_E4E4);
    stream_on = 1'b1;
    pix_ready = 1'b1;
    drain("e4");
    stream_on = 1'b0;
    repeat (3) tick();

    // frame_start with half-full FIFO and underflow set
    pix_ready = 1'b0;
    rdata_mode = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    pix_ready = 1'b1;
    tick();
    pix_ready = 1'b0;
    @(negedge clk);
    check("mid_underflow_set", 32'(underflow), 1);
    check("mid_pix_valid", 32'(pix_valid), 1);
    repeat (7) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    check("flush_pix_valid", 32'(pix_valid), 0);
    check("flush_underflow", 32'(underflow), 0);
    check("flush_mem_addr", mem_addr, 32'h1000);
    tick();
    @(negedge clk);
    check("refetch_mem_addr", mem_addr, 32'h1004);
    check("refetch_pix_valid", 32'(pix_valid), 1);
    check("refetch_pix_data", 32'(pix_data), 0);

    // Reset mid-RUN
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("mrst_pix_valid", 32'(pix_valid), 0);
    check("mrst_pix_data", 32'(pix_data), 0);
    check("mrst_underflow", 32'(underflow), 0);
    check("mrst_mem_addr", mem_addr, 32'h1000);
    tick();
    pix_ready = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    check("mrst_idle_valid", 32'(pix_valid), 0);
    check("mrst_idle_uflow", 32'(underflow), 0);
    check("mrst_idle_addr", mem_addr, 32'h1000);
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
